// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port memory.
// One access in flight; strobes held MEM_LATENCY cycles, then a one-cycle done.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              mem_ce_o,
    output logic              mem_r_o,
    output logic              mem_w_o,
    output logic              mem_oe_o,
    output logic [ADDR_W-1:0] addr_bus_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q;
    logic              last_q;
    logic              port_q;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic              gnt0_q, gnt1_q, done0_q, done1_q;
    logic              ce_q, r_q, w_q, oe_q;
    logic [ADDR_W-1:0] addr_bus_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              grant0_d, grant1_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // last_q = 1 means port 1 was served last, so port 0 wins a tie.
    always_comb begin
        grant0_d = req0_i & (~req1_i | last_q);
        grant1_d = req1_i & (~req0_i | ~last_q);
        we_d     = grant1_d ? we1_i    : we0_i;
        addr_d   = grant1_d ? addr1_i  : addr0_i;
        wdata_d  = grant1_d ? wdata1_i : wdata0_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            ce_q        <= 1'b0;
            r_q         <= 1'b0;
            w_q         <= 1'b0;
            oe_q        <= 1'b0;
            addr_bus_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_d || grant1_d) begin
                        state_q     <= ACCESS;
                        port_q      <= grant1_d;
                        last_q      <= grant1_d;
                        gnt0_q      <= grant0_d;
                        gnt1_q      <= grant1_d;
                        we_q        <= we_d;
                        cnt_q       <= '0;
                        ce_q        <= 1'b1;
                        r_q         <= ~we_d;
                        oe_q        <= ~we_d;
                        w_q         <= we_d;
                        addr_bus_q  <= addr_d;
                        mem_wdata_q <= we_d ? wdata_d : '0;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        ce_q        <= 1'b0;
                        r_q         <= 1'b0;
                        w_q         <= 1'b0;
                        oe_q        <= 1'b0;
                        addr_bus_q  <= '0;
                        mem_wdata_q <= '0;
                        done0_q     <= ~port_q;
                        done1_q     <= port_q;
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign mem_ce_o    = ce_q;
    assign mem_r_o     = r_q;
    assign mem_w_o     = w_q;
    assign mem_oe_o    = oe_q;
    assign addr_bus_o  = addr_bus_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
